// File: rtl/sobel_frame_scheduler_if.sv
// Handshake bundle between the ping-pong frame scheduler, the capture writer and the Sobel/move engine.
// SOBEL_SCHED_TIMEOUT_EN adds the engine abort pulse and the timeout error counter.
interface sobel_frame_scheduler_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  cfg_enable;
  logic                  cfg_run;
  logic                  cap_done;
  logic [ADDR_WIDTH-1:0] cap_num_cnt;
  logic                  cap_bank;
  logic                  cap_en;
  logic                  eng_start;
  logic                  eng_bank;
  logic [ADDR_WIDTH-1:0] eng_num_cnt;
  logic                  eng_run;
  logic                  eng_done;
  logic [2:0]            o_state;
  logic                  o_busy;
  logic [CNT_WIDTH-1:0]  o_frame_cnt;
  logic [CNT_WIDTH-1:0]  o_drop_cnt;
`ifdef SOBEL_SCHED_TIMEOUT_EN
  logic                  eng_abort;
  logic [CNT_WIDTH-1:0]  o_err_cnt;
`endif

  modport master (
    input  cfg_enable, cfg_run, cap_done, cap_num_cnt, eng_done,
    output cap_bank, cap_en, eng_start, eng_bank, eng_num_cnt, eng_run,
           o_state, o_busy, o_frame_cnt, o_drop_cnt
`ifdef SOBEL_SCHED_TIMEOUT_EN
    , output eng_abort, o_err_cnt
`endif
  );

  modport slave (
    output cfg_enable, cfg_run, cap_done, cap_num_cnt, eng_done,
    input  cap_bank, cap_en, eng_start, eng_bank, eng_num_cnt, eng_run,
           o_state, o_busy, o_frame_cnt, o_drop_cnt
`ifdef SOBEL_SCHED_TIMEOUT_EN
    , input eng_abort, o_err_cnt
`endif
  );
endinterface

// File: rtl/sobel_frame_scheduler.sv
// Ping-pong frame scheduler: steers capture into a free BRAM bank and hands full banks to the engine.
// Optional engine watchdog enabled by defining SOBEL_SCHED_TIMEOUT_EN.
module sobel_frame_scheduler #(
  parameter int ADDR_WIDTH     = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic                    clk,
  input logic                    rst,
  sobel_frame_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_PROC  = 3'd3,
    S_REL   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    B_FREE = 2'd0,
    B_FULL = 2'd1,
    B_BUSY = 2'd2
  } bank_st_t;

  state_t                r_state;
  bank_st_t              r_bank_st [2];
  logic [ADDR_WIDTH-1:0] r_bank_cnt [2];
  logic                  r_cap_bank;
  logic                  r_cap_en;
  logic                  r_eng_start;
  logic                  r_eng_bank;
  logic [ADDR_WIDTH-1:0] r_eng_num_cnt;
  logic                  r_eng_run;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;

`ifdef SOBEL_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_eng_abort;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic                  w_timeout;
`endif

  logic w_other;
  logic w_cap_evt;
  logic w_other_free;
  logic w_accept;
  logic w_drop;
  logic w_full_any;
  logic w_full_sel;

  // The capture-owned bank is always FREE, so at most one other bank can be FULL or BUSY.
  // A bank being released in S_REL is already free for the capture decision.
  assign w_other      = ~r_cap_bank;
  assign w_cap_evt    = bus.cap_done & r_cap_en;
  assign w_other_free = (r_bank_st[w_other] == B_FREE) ||
                        ((r_state == S_REL) && (r_bank_st[w_other] == B_BUSY));
  assign w_accept     = w_cap_evt & w_other_free;
  assign w_drop       = w_cap_evt & ~w_other_free;
  assign w_full_any   = (r_bank_st[0] == B_FULL) || (r_bank_st[1] == B_FULL);
  assign w_full_sel   = (r_bank_st[0] == B_FULL) ? 1'b0 : 1'b1;

`ifdef SOBEL_SCHED_TIMEOUT_EN
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bank_cnt[r_cap_bank] <= bus.cap_num_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bank_st[0]  <= B_FREE;
      r_bank_st[1]  <= B_FREE;
      r_cap_bank    <= 1'b0;
      r_cap_en      <= 1'b0;
      r_eng_start   <= 1'b0;
      r_eng_bank    <= 1'b0;
      r_eng_num_cnt <= '0;
      r_eng_run     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= '0;
      r_drop_cnt    <= '0;
`ifdef SOBEL_SCHED_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_eng_abort   <= 1'b0;
      r_err_cnt     <= '0;
`endif
    end else begin
      r_cap_en    <= bus.cfg_enable;
      r_eng_start <= 1'b0;
`ifdef SOBEL_SCHED_TIMEOUT_EN
      r_eng_abort <= 1'b0;
`endif

      if (w_accept) begin
        r_bank_st[r_cap_bank] <= B_FULL;
        r_cap_bank            <= ~r_cap_bank;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (bus.cfg_enable) begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!bus.cfg_enable) begin
            r_state <= S_IDLE;
          end else if (w_full_any) begin
            r_state                <= S_START;
            r_busy                 <= 1'b1;
            r_eng_start            <= 1'b1;
            r_eng_bank             <= w_full_sel;
            r_eng_num_cnt          <= r_bank_cnt[w_full_sel];
            r_eng_run              <= bus.cfg_run;
            r_bank_st[w_full_sel]  <= B_BUSY;
          end
        end

        S_START: begin
          r_state <= S_PROC;
`ifdef SOBEL_SCHED_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end

        S_PROC: begin
          if (bus.eng_done) begin
            r_state <= S_REL;
`ifdef SOBEL_SCHED_TIMEOUT_EN
          end else if (w_timeout) begin
            r_state     <= S_REL;
            r_eng_abort <= 1'b1;
            r_err_cnt   <= r_err_cnt + CNT_WIDTH'(1);
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
          end
        end

        S_REL: begin
          r_bank_st[r_eng_bank] <= B_FREE;
          r_busy                <= 1'b0;
`ifdef SOBEL_SCHED_TIMEOUT_EN
          if (!r_eng_abort) begin
            r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
          end
`else
          r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
`endif
          r_state <= bus.cfg_enable ? S_WAIT : S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the two-bank ownership scheme.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!((r_bank_st[0] == B_BUSY) && (r_bank_st[1] == B_BUSY)));
      assert (!((r_bank_st[r_eng_bank] == B_BUSY) && (r_eng_bank == r_cap_bank)));
      assert (TIMEOUT_CYCLES > 0);
    end
  end

  assign bus.cap_bank    = r_cap_bank;
  assign bus.cap_en      = r_cap_en;
  assign bus.eng_start   = r_eng_start;
  assign bus.eng_bank    = r_eng_bank;
  assign bus.eng_num_cnt = r_eng_num_cnt;
  assign bus.eng_run     = r_eng_run;
  assign bus.o_state     = r_state;
  assign bus.o_busy      = r_busy;
  assign bus.o_frame_cnt = r_frame_cnt;
  assign bus.o_drop_cnt  = r_drop_cnt;
`ifdef SOBEL_SCHED_TIMEOUT_EN
  assign bus.eng_abort   = r_eng_abort;
  assign bus.o_err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed bench for the ping-pong frame scheduler: capture/start latency, drop, REL bypass, disable and reset.
module tb_sobel_frame_scheduler;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  sobel_frame_scheduler_if #(.ADDR_WIDTH(16), .CNT_WIDTH(16)) bus ();

  sobel_frame_scheduler #(.ADDR_WIDTH(16), .CNT_WIDTH(16), .TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_enable = 1'b0; bus.cfg_run = 1'b0; bus.cap_done = 1'b0;
    bus.cap_num_cnt = '0; bus.eng_done = 1'b0;
    step(); step(); step();
    n_chk++; if (bus.o_state !== 3'd0) $display("FAIL rst_state got %0d exp 0", bus.o_state); else n_pass++;
    n_chk++; if (bus.cap_bank !== 1'b0) $display("FAIL rst_cap_bank got %0d exp 0", bus.cap_bank); else n_pass++;
    n_chk++; if (bus.cap_en !== 1'b0) $display("FAIL rst_cap_en got %0d exp 0", bus.cap_en); else n_pass++;
    n_chk++; if (bus.eng_start !== 1'b0) $display("FAIL rst_eng_start got %0d exp 0", bus.eng_start); else n_pass++;
    n_chk++; if (bus.eng_num_cnt !== 16'd0) $display("FAIL rst_eng_num got %0d exp 0", bus.eng_num_cnt); else n_pass++;
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy got %0d exp 0", bus.o_busy); else n_pass++;
    n_chk++; if (bus.o_frame_cnt !== 16'd0) $display("FAIL rst_frame got %0d exp 0", bus.o_frame_cnt); else n_pass++;
    n_chk++; if (bus.o_drop_cnt !== 16'd0) $display("FAIL rst_drop got %0d exp 0", bus.o_drop_cnt); else n_pass++;
    rst = 1'b0;
    bus.cfg_enable = 1'b1;
    step();
    n_chk++; if (bus.o_state !== 3'd1) $display("FAIL en_state got %0d exp 1", bus.o_state); else n_pass++;
    n_chk++; if (bus.cap_en !== 1'b1) $display("FAIL en_cap_en got %0d exp 1", bus.cap_en); else n_pass++;
  endtask

  task automatic test_capture_start();
    bus.cfg_run = 1'b1;
    bus.cap_done = 1'b1; bus.cap_num_cnt = 16'd58590;
    step();
    bus.cap_done = 1'b0;
    n_chk++; if (bus.cap_bank !== 1'b1) $display("FAIL cs_cap_bank got %0d exp 1", bus.cap_bank); else n_pass++;
    n_chk++; if (bus.eng_start !== 1'b0) $display("FAIL cs_early_start got %0d exp 0", bus.eng_start); else n_pass++;
    step();
    n_chk++; if (bus.o_state !== 3'd2) $display("FAIL cs_state got %0d exp 2", bus.o_state); else n_pass++;
    n_chk++; if (bus.eng_start !== 1'b1) $display("FAIL cs_eng_start got %0d exp 1", bus.eng_start); else n_pass++;
    n_chk++; if (bus.eng_bank !== 1'b0) $display("FAIL cs_eng_bank got %0d exp 0", bus.eng_bank); else n_pass++;
    n_chk++; if (bus.eng_num_cnt !== 16'd58590) $display("FAIL cs_eng_num got %0d exp 58590", bus.eng_num_cnt); else n_pass++;
    n_chk++; if (bus.eng_run !== 1'b1) $display("FAIL cs_eng_run got %0d exp 1", bus.eng_run); else n_pass++;
    n_chk++; if (bus.o_busy !== 1'b1) $display("FAIL cs_busy got %0d exp 1", bus.o_busy); else n_pass++;
    step();
    n_chk++; if (bus.o_state !== 3'd3) $display("FAIL cs_proc got %0d exp 3", bus.o_state); else n_pass++;
    n_chk++; if (bus.eng_start !== 1'b0) $display("FAIL cs_start_pulse got %0d exp 0", bus.eng_start); else n_pass++;
  endtask

  task automatic test_drop();
    bus.cap_done = 1'b1; bus.cap_num_cnt = 16'd100;
    step();
    bus.cap_done = 1'b0;
    n_chk++; if (bus.o_drop_cnt !== 16'd1) $display("FAIL drop_cnt got %0d exp 1", bus.o_drop_cnt); else n_pass++;
    n_chk++; if (bus.cap_bank !== 1'b1) $display("FAIL drop_cap_bank got %0d exp 1", bus.cap_bank); else n_pass++;
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    n_chk++; if (bus.o_state !== 3'd4) $display("FAIL drop_rel got %0d exp 4", bus.o_state); else n_pass++;
    step();
    n_chk++; if (bus.o_state !== 3'd1) $display("FAIL drop_wait got %0d exp 1", bus.o_state); else n_pass++;
    n_chk++; if (bus.o_frame_cnt !== 16'd1) $display("FAIL drop_frame got %0d exp 1", bus.o_frame_cnt); else n_pass++;
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL drop_busy got %0d exp 0", bus.o_busy); else n_pass++;
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    n_chk++; if (bus.o_state !== 3'd1) $display("FAIL stray_done_state got %0d exp 1", bus.o_state); else n_pass++;
    n_chk++; if (bus.o_frame_cnt !== 16'd1) $display("FAIL stray_done_frame got %0d exp 1", bus.o_frame_cnt); else n_pass++;
  endtask

  task automatic test_bypass();
    bus.cfg_run = 1'b0;
    bus.cap_done = 1'b1; bus.cap_num_cnt = 16'd1000;
    step();
    bus.cap_done = 1'b0;
    n_chk++; if (bus.cap_bank !== 1'b0) $display("FAIL bp_cap_bank got %0d exp 0", bus.cap_bank); else n_pass++;
    step();
    n_chk++; if (bus.eng_bank !== 1'b1) $display("FAIL bp_eng_bank got %0d exp 1", bus.eng_bank); else n_pass++;
    n_chk++; if (bus.eng_num_cnt !== 16'd1000) $display("FAIL bp_eng_num got %0d exp 1000", bus.eng_num_cnt); else n_pass++;
    n_chk++; if (bus.eng_run !== 1'b0) $display("FAIL bp_eng_run got %0d exp 0", bus.eng_run); else n_pass++;
    step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    n_chk++; if (bus.o_state !== 3'd4) $display("FAIL bp_rel got %0d exp 4", bus.o_state); else n_pass++;
    bus.cap_done = 1'b1; bus.cap_num_cnt = 16'd2000; bus.cfg_run = 1'b1;
    step();
    bus.cap_done = 1'b0;
    n_chk++; if (bus.o_drop_cnt !== 16'd1) $display("FAIL bp_no_drop got %0d exp 1", bus.o_drop_cnt); else n_pass++;
    n_chk++; if (bus.cap_bank !== 1'b1) $display("FAIL bp_cap_bank2 got %0d exp 1", bus.cap_bank); else n_pass++;
    n_chk++; if (bus.o_frame_cnt !== 16'd2) $display("FAIL bp_frame got %0d exp 2", bus.o_frame_cnt); else n_pass++;
    step();
    n_chk++; if (bus.eng_start !== 1'b1) $display("FAIL bp_start got %0d exp 1", bus.eng_start); else n_pass++;
    n_chk++; if (bus.eng_bank !== 1'b0) $display("FAIL bp_eng_bank2 got %0d exp 0", bus.eng_bank); else n_pass++;
    n_chk++; if (bus.eng_num_cnt !== 16'd2000) $display("FAIL bp_eng_num2 got %0d exp 2000", bus.eng_num_cnt); else n_pass++;
    n_chk++; if (bus.eng_run !== 1'b1) $display("FAIL bp_eng_run2 got %0d exp 1", bus.eng_run); else n_pass++;
  endtask

  task automatic test_disable_midframe();
    step();
    bus.cfg_enable = 1'b0; bus.cfg_run = 1'b0;
    step();
    n_chk++; if (bus.o_state !== 3'd3) $display("FAIL dis_state got %0d exp 3", bus.o_state); else n_pass++;
    n_chk++; if (bus.cap_en !== 1'b0) $display("FAIL dis_cap_en got %0d exp 0", bus.cap_en); else n_pass++;
    n_chk++; if (bus.eng_run !== 1'b1) $display("FAIL dis_eng_run got %0d exp 1", bus.eng_run); else n_pass++;
    bus.cap_done = 1'b1; bus.cap_num_cnt = 16'd5;
    step();
    bus.cap_done = 1'b0;
    n_chk++; if (bus.o_drop_cnt !== 16'd1) $display("FAIL dis_ign_drop got %0d exp 1", bus.o_drop_cnt); else n_pass++;
    n_chk++; if (bus.cap_bank !== 1'b1) $display("FAIL dis_ign_bank got %0d exp 1", bus.cap_bank); else n_pass++;
    n_chk++; if (bus.eng_num_cnt !== 16'd2000) $display("FAIL dis_num_stable got %0d exp 2000", bus.eng_num_cnt); else n_pass++;
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    n_chk++; if (bus.o_state !== 3'd4) $display("FAIL dis_rel got %0d exp 4", bus.o_state); else n_pass++;
    step();
    n_chk++; if (bus.o_state !== 3'd0) $display("FAIL dis_idle got %0d exp 0", bus.o_state); else n_pass++;
    n_chk++; if (bus.o_frame_cnt !== 16'd3) $display("FAIL dis_frame got %0d exp 3", bus.o_frame_cnt); else n_pass++;
  endtask

  task automatic test_persist();
    bus.cfg_enable = 1'b1;
    step();
    bus.cap_done = 1'b1; bus.cap_num_cnt = 16'd42; bus.cfg_enable = 1'b0;
    step();
    bus.cap_done = 1'b0;
    n_chk++; if (bus.o_state !== 3'd0) $display("FAIL ps_idle got %0d exp 0", bus.o_state); else n_pass++;
    n_chk++; if (bus.cap_bank !== 1'b0) $display("FAIL ps_cap_bank got %0d exp 0", bus.cap_bank); else n_pass++;
    step(); step();
    n_chk++; if (bus.eng_start !== 1'b0) $display("FAIL ps_no_start got %0d exp 0", bus.eng_start); else n_pass++;
    bus.cfg_enable = 1'b1;
    step();
    step();
    n_chk++; if (bus.eng_start !== 1'b1) $display("FAIL ps_start got %0d exp 1", bus.eng_start); else n_pass++;
    n_chk++; if (bus.eng_bank !== 1'b1) $display("FAIL ps_eng_bank got %0d exp 1", bus.eng_bank); else n_pass++;
    n_chk++; if (bus.eng_num_cnt !== 16'd42) $display("FAIL ps_eng_num got %0d exp 42", bus.eng_num_cnt); else n_pass++;
    step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    step();
    n_chk++; if (bus.o_state !== 3'd1) $display("FAIL ps_wait got %0d exp 1", bus.o_state); else n_pass++;
    n_chk++; if (bus.o_frame_cnt !== 16'd4) $display("FAIL ps_frame got %0d exp 4", bus.o_frame_cnt); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bus.cap_done = 1'b1; bus.cap_num_cnt = 16'd7;
    step();
    bus.cap_done = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (bus.eng_start !== 1'b0) $display("FAIL mr_no_start got %0d exp 0", bus.eng_start); else n_pass++;
    n_chk++; if (bus.o_state !== 3'd0) $display("FAIL mr_state got %0d exp 0", bus.o_state); else n_pass++;
    n_chk++; if (bus.cap_bank !== 1'b0) $display("FAIL mr_cap_bank got %0d exp 0", bus.cap_bank); else n_pass++;
    n_chk++; if (bus.o_frame_cnt !== 16'd0) $display("FAIL mr_frame got %0d exp 0", bus.o_frame_cnt); else n_pass++;
    n_chk++; if (bus.o_drop_cnt !== 16'd0) $display("FAIL mr_drop got %0d exp 0", bus.o_drop_cnt); else n_pass++;
    step(); step(); step();
    n_chk++; if (bus.o_state !== 3'd1) $display("FAIL mr_no_full got %0d exp 1", bus.o_state); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_capture_start();
    test_drop();
    test_bypass();
    test_disable_midframe();
    test_persist();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
